// File: rtl/second_game_controller.sv
// Frame-stepped controller for a dodge-the-obstacles game: moves the player
// square, tracks lives and score, and freezes the player for a while after a hit.
module second_game_controller #(
  parameter int SECOND_GAME_SCREEN_WIDTH  = 400,
  parameter int SECOND_GAME_SCREEN_HEIGHT = 600,
  parameter int SECOND_GAME_PLAYER_SIZE   = 20,
  parameter int SECOND_GAME_STEP          = 4,
  parameter int SECOND_GAME_LIVES         = 3,
  parameter int SECOND_GAME_HIT_FRAMES    = 60
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic                                          i_start,
  input  logic                                          i_btn_left,
  input  logic                                          i_btn_right,
  input  logic                                          i_btn_up,
  input  logic                                          i_btn_down,
  input  logic                                          i_frame_tick,
  input  logic                                          i_in_player,
  input  logic                                          i_is_obstacle,
  output logic [$clog2(SECOND_GAME_SCREEN_WIDTH)-1:0]   o_screen_square_x,
  output logic [$clog2(SECOND_GAME_SCREEN_HEIGHT)-1:0]  o_screen_square_y,
  output logic [1:0]                                    o_state,
  output logic [2:0]                                    o_lives,
  output logic [15:0]                                   o_score
);

  localparam int XW = $clog2(SECOND_GAME_SCREEN_WIDTH);
  localparam int YW = $clog2(SECOND_GAME_SCREEN_HEIGHT);

  localparam logic [XW-1:0] X_INIT = XW'(SECOND_GAME_SCREEN_WIDTH / 2);
  localparam logic [YW-1:0] Y_INIT =
    YW'(SECOND_GAME_SCREEN_HEIGHT - SECOND_GAME_PLAYER_SIZE - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(SECOND_GAME_LIVES);
  localparam logic [7:0]    CNT_INIT   = 8'(SECOND_GAME_HIT_FRAMES - 1);

  // Two extra bits give a sign bit plus headroom so a step past either edge
  // never wraps before it is clamped.
  localparam logic signed [XW+1:0] X_MIN  = (XW+2)'(SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [XW+1:0] X_MAX  =
    (XW+2)'(SECOND_GAME_SCREEN_WIDTH - 1 - SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [XW+1:0] X_STEP = (XW+2)'(SECOND_GAME_STEP);
  localparam logic signed [YW+1:0] Y_MIN  = (YW+2)'(SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [YW+1:0] Y_MAX  =
    (YW+2)'(SECOND_GAME_SCREEN_HEIGHT - 1 - SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [YW+1:0] Y_STEP = (YW+2)'(SECOND_GAME_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [XW-1:0]  x, x_n;
  logic [YW-1:0]  y, y_n;
  logic [2:0]     lives, lives_n;
  logic [15:0]    score, score_n;
  logic           hit_flag, hit_flag_n;
  logic [7:0]     hit_cnt, hit_cnt_n;

  logic                   collide;
  logic signed [XW+1:0]   x_delta, x_move, x_clamp;
  logic signed [YW+1:0]   y_delta, y_move, y_clamp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      x        <= X_INIT;
      y        <= Y_INIT;
      lives    <= LIVES_INIT;
      score    <= 16'd0;
      hit_flag <= 1'b0;
      hit_cnt  <= 8'd0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      lives    <= lives_n;
      score    <= score_n;
      hit_flag <= hit_flag_n;
      hit_cnt  <= hit_cnt_n;
    end
  end

  // Candidate position for this frame; opposing buttons cancel on their axis.
  always_comb begin
    x_delta = '0;
    y_delta = '0;
    if (i_btn_right && !i_btn_left) x_delta = X_STEP;
    if (i_btn_left && !i_btn_right) x_delta = -X_STEP;
    if (i_btn_down && !i_btn_up)    y_delta = Y_STEP;
    if (i_btn_up && !i_btn_down)    y_delta = -Y_STEP;
    x_move = $signed({2'b00, x}) + x_delta;
    y_move = $signed({2'b00, y}) + y_delta;
    if (x_move < X_MIN)      x_clamp = X_MIN;
    else if (x_move > X_MAX) x_clamp = X_MAX;
    else                     x_clamp = x_move;
    if (y_move < Y_MIN)      y_clamp = Y_MIN;
    else if (y_move > Y_MAX) y_clamp = Y_MAX;
    else                     y_clamp = y_move;
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    lives_n    = lives;
    score_n    = score;
    hit_flag_n = hit_flag;
    hit_cnt_n  = hit_cnt;
    collide    = i_in_player && i_is_obstacle;

    case (state)
      IDLE, OVER: begin
        if (i_start) begin
          state_n    = PLAY;
          x_n        = X_INIT;
          y_n        = Y_INIT;
          lives_n    = LIVES_INIT;
          score_n    = 16'd0;
          hit_flag_n = 1'b0;
        end
      end
      PLAY: begin
        if (i_frame_tick) begin
          hit_flag_n = 1'b0;
          // A collision on the tick cycle itself belongs to the frame just ending.
          if (hit_flag || collide) begin
            lives_n   = lives - 3'd1;
            hit_cnt_n = CNT_INIT;
            state_n   = (lives <= 3'd1) ? OVER : HIT;
          end else begin
            x_n = x_clamp[XW-1:0];
            y_n = y_clamp[YW-1:0];
            if (score != 16'hFFFF) score_n = score + 16'd1;
          end
        end else if (collide) begin
          hit_flag_n = 1'b1;
        end
      end
      HIT: begin
        if (i_frame_tick) begin
          if (hit_cnt == 8'd0) begin
            state_n    = PLAY;
            hit_flag_n = 1'b0;
          end else begin
            hit_cnt_n = hit_cnt - 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_state           = state;
  assign o_screen_square_x = x;
  assign o_screen_square_y = y;
  assign o_lives           = lives;
  assign o_score           = score;

endmodule

// File: tb/tb_second_game_controller.sv
// Self-checking bench for second_game_controller: vector table, scripted game
// sequences, and random play compared against a frame-level game model.
module tb_second_game_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic        tick = 1'b0, in_player = 1'b0, is_obstacle = 1'b0;
  logic [8:0]  sx;
  logic [9:0]  sy;
  logic [1:0]  st;
  logic [2:0]  lives;
  logic [15:0] score;

  int tests = 0;
  int fails = 0;

  // Game model: whole-game quantities kept as plain integers.
  int m_state, m_x, m_y, m_lives, m_score, m_flag, m_cnt;

  second_game_controller dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .i_btn_left        (left),
    .i_btn_right       (right),
    .i_btn_up          (up),
    .i_btn_down        (down),
    .i_frame_tick      (tick),
    .i_in_player       (in_player),
    .i_is_obstacle     (is_obstacle),
    .o_screen_square_x (sx),
    .o_screen_square_y (sy),
    .o_state           (st),
    .o_lives           (lives),
    .o_score           (score)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_x = 200; m_y = 579; m_lives = 3;
    m_score = 0; m_flag = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    int dx, dy;
    bit collide;
    collide = in_player && is_obstacle;
    if (m_state == 0 || m_state == 3) begin
      if (start) begin
        m_state = 1; m_x = 200; m_y = 579; m_lives = 3; m_score = 0; m_flag = 0;
      end
    end else if (m_state == 1) begin
      if (tick) begin
        if (m_flag != 0 || collide) begin
          m_lives = m_lives - 1;
          m_cnt   = 59;
          m_state = (m_lives == 0) ? 3 : 2;
        end else begin
          dx = (right ? 4 : 0) - (left ? 4 : 0);
          dy = (down ? 4 : 0) - (up ? 4 : 0);
          m_x = clampi(m_x + dx, 20, 379);
          m_y = clampi(m_y + dy, 20, 579);
          if (m_score < 65535) m_score = m_score + 1;
        end
        m_flag = 0;
      end else if (collide) begin
        m_flag = 1;
      end
    end else begin
      if (tick) begin
        if (m_cnt == 0) begin m_state = 1; m_flag = 0; end
        else m_cnt = m_cnt - 1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int es, input int ex,
                             input int ey, input int el, input int esc);
    tests++;
    if ({st, sx, sy, lives, score} !== {2'(es), 9'(ex), 10'(ey), 3'(el), 16'(esc)}) begin
      fails++;
      $display("[TB] FAIL %s: got state=%0d x=%0d y=%0d lives=%0d score=%0d, expected state=%0d x=%0d y=%0d lives=%0d score=%0d",
               name, st, sx, sy, lives, score, es, ex, ey, el, esc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic r,
                               input logic u, input logic d, input logic t,
                               input logic ip, input logic ob);
    start = s; left = l; right = r; up = u; down = d;
    tick = t; in_player = ip; is_obstacle = ob;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic l, input logic r, input logic u,
                       input logic d, input logic ip, input logic ob);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, l, r, u, d, 1'b1, ip, ob);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 0; left = 0; right = 0; up = 0; down = 0;
    tick = 0; in_player = 0; is_obstacle = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic s, l, r, u, d, t, ip, ob;
    int   es, ex, ey, el, esc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // {start,left,right,up,down,tick,in_player,obstacle, state,x,y,lives,score}
    vecs[0]  = '{0,0,0,0,0,0,0,0, 0,200,579,3,0};
    vecs[1]  = '{0,1,0,0,0,1,0,0, 0,200,579,3,0};
    vecs[2]  = '{1,0,0,0,0,0,0,0, 1,200,579,3,0};
    vecs[3]  = '{0,0,1,0,0,1,0,0, 1,204,579,3,1};
    vecs[4]  = '{0,0,0,1,0,1,0,0, 1,204,575,3,2};
    vecs[5]  = '{0,1,1,0,1,1,0,0, 1,204,579,3,3};
    vecs[6]  = '{0,0,0,1,0,0,0,0, 1,204,579,3,3};
    vecs[7]  = '{0,1,0,1,0,1,0,0, 1,200,575,3,4};
    vecs[8]  = '{1,0,0,0,0,1,0,0, 1,200,575,3,5};
    vecs[9]  = '{0,0,0,0,0,1,1,0, 1,200,575,3,6};
    vecs[10] = '{0,0,0,0,0,0,1,1, 1,200,575,3,6};
    vecs[11] = '{0,0,0,0,0,1,0,0, 2,200,575,2,6};

    doReset();
    checkOutput("reset_state", 0, 200, 579, 3, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].s, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d,
                    vecs[i].t, vecs[i].ip, vecs[i].ob);
      checkOutput($sformatf("vector_%0d", i), vecs[i].es, vecs[i].ex,
                  vecs[i].ey, vecs[i].el, vecs[i].esc);
    end

    // Start and score counting, then edge clamping.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("start", 1, 200, 579, 3, 0);
    ticks(10, 0, 0, 0, 0, 0, 0);
    checkOutput("score_10", 1, 200, 579, 3, 10);
    ticks(60, 1, 0, 0, 0, 0, 0);
    checkOutput("clamp_left", 1, 20, 579, 3, 70);
    ticks(1, 1, 0, 0, 0, 0, 0);
    checkOutput("clamp_left_hold", 1, 20, 579, 3, 71);
    ticks(5, 0, 0, 0, 1, 0, 0);
    checkOutput("clamp_down", 1, 20, 579, 3, 76);
    ticks(5, 0, 1, 0, 0, 0, 0);
    checkOutput("move_right", 1, 40, 579, 3, 81);
    ticks(3, 1, 1, 0, 0, 0, 0);
    checkOutput("left_right_cancel", 1, 40, 579, 3, 84);

    // Hits, freeze period, ignored collisions while frozen, game over, restart.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    ticks(3, 0, 0, 1, 0, 0, 0);
    checkOutput("move_up", 1, 200, 567, 3, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("collide_no_tick", 1, 200, 567, 3, 3);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("hit_enter", 2, 200, 567, 2, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("start_ignored_hit", 2, 200, 567, 2, 3);
    ticks(30, 1, 0, 0, 0, 1, 1);
    ticks(29, 0, 0, 0, 0, 0, 0);
    checkOutput("hit_59_ticks", 2, 200, 567, 2, 3);
    ticks(1, 0, 0, 0, 0, 0, 0);
    checkOutput("hit_recover", 1, 200, 567, 2, 3);
    ticks(1, 0, 1, 0, 0, 0, 0);
    checkOutput("move_after_recover", 1, 204, 567, 2, 4);
    ticks(1, 0, 1, 0, 0, 1, 1);
    checkOutput("hit_coincident", 2, 204, 567, 1, 4);
    ticks(60, 0, 0, 0, 0, 0, 0);
    checkOutput("hit2_recover", 1, 204, 567, 1, 4);
    ticks(1, 0, 0, 0, 0, 1, 1);
    checkOutput("game_over", 3, 204, 567, 0, 4);
    ticks(3, 1, 0, 0, 0, 0, 0);
    checkOutput("over_hold", 3, 204, 567, 0, 4);
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("restart_with_tick", 1, 200, 579, 3, 0);

    // Asynchronous reset in the middle of play.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    ticks(25, 1, 0, 0, 0, 0, 0);
    ticks(12, 0, 0, 0, 0, 0, 0);
    checkOutput("before_async_reset", 1, 100, 579, 3, 37);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_reset", 0, 200, 579, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random play against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      checkOutput($sformatf("random_%0d", i), m_state, m_x, m_y, m_lives, m_score);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/second_game_controller.md
SECOND_GAME_CONTROLLER -- requirements
Module: second_game_controller

Interface
REQ-001 SHALL have parameter SECOND_GAME_SCREEN_WIDTH, default 400, playfield width in pixels.
REQ-002 SHALL have parameter SECOND_GAME_SCREEN_HEIGHT, default 600, playfield height in pixels.
REQ-003 SHALL have parameter SECOND_GAME_PLAYER_SIZE, default 20, player square half-size in pixels.
REQ-004 SHALL have parameter SECOND_GAME_STEP, default 4, player move per frame in pixels.
REQ-005 SHALL have parameter SECOND_GAME_LIVES, default 3, lives at game start (1..7).
REQ-006 SHALL have parameter SECOND_GAME_HIT_FRAMES, default 60, frames of invulnerable freeze after a hit (1..255).
REQ-007 SHALL have port i_clk, input, 1, single system clock; all state changes on its rising edge.
REQ-008 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_start, input, 1, level; request a new game.
REQ-010 SHALL have ports i_btn_left, i_btn_right, i_btn_up, i_btn_down, input, 1 each, synchronised button levels.
REQ-011 SHALL have port i_frame_tick, input, 1, one-cycle pulse at start of vertical blanking.
REQ-012 SHALL have port i_in_player, input, 1, current displayed pixel lies inside the player square.
REQ-013 SHALL have port i_is_obstacle, input, 1, current displayed pixel is an obstacle.
REQ-014 SHALL have port o_screen_square_x, output, $clog2(SECOND_GAME_SCREEN_WIDTH), player centre X.
REQ-015 SHALL have port o_screen_square_y, output, $clog2(SECOND_GAME_SCREEN_HEIGHT), player centre Y.
REQ-016 SHALL have port o_state, output, 2, IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-017 SHALL have port o_lives, output, 3, remaining lives.
REQ-018 SHALL have port o_score, output, 16, frames survived in PLAY.

Function
REQ-019 SHALL register all outputs; no combinational input-to-output path.
REQ-020 SHALL implement FSM: IDLE -(i_start)-> PLAY; OVER -(i_start)-> PLAY; PLAY -(frame tick with hit flag, lives>1)-> HIT; PLAY -(frame tick with hit flag, lives==1)-> OVER; HIT -(hit counter reaches 0 on frame tick)-> PLAY.
REQ-021 SHALL, on entry to PLAY from IDLE/OVER, load X=WIDTH/2, Y=HEIGHT-PLAYER_SIZE-1, lives=LIVES, score=0, hit flag=0.
REQ-022 SHALL set a sticky hit flag in any cycle where state==PLAY and i_in_player && i_is_obstacle; collision asserted in the same cycle as i_frame_tick counts for the ending frame.
REQ-023 SHALL, on each i_frame_tick in PLAY, evaluate then clear the hit flag; on hit decrement lives by 1, load hit counter=HIT_FRAMES-1, and skip movement and score for that tick.
REQ-024 SHALL, on each i_frame_tick in PLAY without hit, move X by +STEP (right only) or -STEP (left only), Y by -STEP (up only) or +STEP (down only); opposing buttons both pressed = no move on that axis.
REQ-025 SHALL clamp X to [PLAYER_SIZE, WIDTH-1-PLAYER_SIZE] and Y to [PLAYER_SIZE, HEIGHT-1-PLAYER_SIZE], computing in signed width+2 arithmetic so no wrap-around occurs.
REQ-026 SHALL increment o_score on each non-hit PLAY frame tick, saturating at 16'hFFFF.
REQ-027 SHALL, in HIT, ignore buttons and collisions, decrement hit counter on each frame tick, and return to PLAY (hit flag cleared) on the tick where counter==0.
REQ-028 SHALL ignore i_start in PLAY and HIT; i_start coincident with i_frame_tick in IDLE/OVER enters PLAY with no move or score that cycle.
REQ-029 SHALL hold position, lives and score unchanged in IDLE and OVER; o_lives==0 in OVER.

Reset
REQ-030 SHALL, while i_rst_n==0 (asynchronous, also mid-game), force o_state=IDLE, o_screen_square_x=WIDTH/2 (200), o_screen_square_y=HEIGHT-PLAYER_SIZE-1 (579), o_lives=LIVES (3), o_score=0, hit flag=0, hit counter=0.

Verification
REQ-031 SHALL verify start: reset, pulse i_start -> o_state=1, X=200, Y=579, lives=3, score=0; 10 frame ticks -> score=10.
REQ-032 SHALL verify clamp: PLAY, i_btn_left held 60 ticks -> X=20 and stays 20; i_btn_down held -> Y stays 579; left+right held -> X unchanged.
REQ-033 SHALL verify hit: PLAY, one cycle i_in_player&&i_is_obstacle then tick -> o_state=2, lives=2, score unchanged; after 60 further ticks -> o_state=1, movement resumes.
REQ-034 SHALL verify game over: three hits separated by HIT recovery -> o_state=3, lives=0; i_start -> o_state=1, lives=3, score=0.
REQ-035 SHALL verify collision coincident with frame tick counts as hit; collision during HIT is ignored (lives unchanged after recovery).
REQ-036 SHALL verify i_rst_n asserted mid-PLAY (score=37, X=100) -> outputs immediately at reset values without waiting for i_clk.
